// File: rtl/jtframe_bank_resp.sv
// Single-bank SDRAM request responder backed by an internal BRAM.
// Reproduces SDRAM handshake timing (ack, dst, rdy) and periodic refresh stalls.
module jtframe_bank_resp #(
  parameter int AW         = 22,
  parameter int MW         = 10,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 2,
  parameter int REF_PERIOD = 384,
  parameter int REF_LEN    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          rd,
  input  logic          wr,
  input  logic [15:0]   din,
  input  logic [1:0]    din_m,
  output logic          ack,
  output logic          dst,
  output logic          rdy,
  output logic [15:0]   data_read,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, DONE, REFRESH} state_t;

  localparam logic [7:0]  RD_DST   = 8'(RD_LAT - 1);
  localparam logic [7:0]  RD_RDY   = 8'(RD_LAT);
  localparam logic [7:0]  RD_END   = 8'(RD_LAT + 1);
  localparam logic [7:0]  WR_RDY   = 8'(WR_LAT - 1);
  localparam logic [7:0]  WR_END   = 8'(WR_LAT);
  localparam logic [7:0]  REF_END  = 8'(REF_LEN);
  localparam logic [15:0] REF_LAST = 16'(REF_PERIOD - 1);

  state_t        state;
  logic [7:0]    cnt;
  logic [15:0]   rcnt;
  logic          pending;
  logic          wrap;
  logic          ld_rd;
  logic          we;
  logic [MW-1:0] rd_addr;
  logic [MW-1:0] addr_p1;
  logic [15:0]   din_p1;
  logic [1:0]    din_m_p1;
  logic [15:0]   mem [0:(2**MW)-1];
  logic          addr_hi_unused;

  // Upper address bits alias onto the same words.
  assign addr_hi_unused = ^addr[AW-1:MW];

  assign wrap    = (REF_PERIOD != 0) && (rcnt == REF_LAST);
  assign busy    = (state != IDLE);
  assign rd_addr = (state == IDLE) ? addr[MW-1:0] : addr_p1;
  assign ld_rd   = ((state == IDLE) && (RD_LAT == 1) && !pending && !wrap && !wr && rd) ||
                   ((state == RD_WAIT) && (cnt == RD_DST));
  assign we      = !rst && (state == WR_WAIT) && (cnt == 8'd1);

  // Stage p1: request operands captured on the accepting edge
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      addr_p1  <= addr[MW-1:0];
      din_p1   <= din;
      din_m_p1 <= din_m;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !din_m_p1[0]) mem[addr_p1][7:0]  <= din_p1[7:0];
    if (we && !din_m_p1[1]) mem[addr_p1][15:8] <= din_p1[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      pending   <= 1'b0;
      ack       <= 1'b0;
      dst       <= 1'b0;
      rdy       <= 1'b0;
      data_read <= '0;
    end else begin
      ack  <= 1'b0;
      dst  <= 1'b0;
      rdy  <= 1'b0;
      cnt  <= cnt + 8'd1;
      rcnt <= wrap ? '0 : rcnt + 16'd1;
      if (ld_rd) data_read <= mem[rd_addr];
      case (state)
        IDLE: begin
          cnt <= 8'd1;
          if (pending || wrap) begin
            state   <= REFRESH;
            pending <= 1'b1;
          end else if (wr) begin
            state <= WR_WAIT;
            ack   <= 1'b1;
            rdy   <= (WR_LAT == 1);
          end else if (rd) begin
            state <= RD_WAIT;
            ack   <= 1'b1;
            dst   <= (RD_LAT == 1);
          end
        end
        RD_WAIT: begin
          if (wrap) pending <= 1'b1;
          if (cnt == RD_DST) dst <= 1'b1;
          if (cnt == RD_RDY) rdy <= 1'b1;
          if (cnt == RD_END) state <= DONE;
        end
        WR_WAIT: begin
          if (wrap) pending <= 1'b1;
          if (cnt == WR_RDY) rdy <= 1'b1;
          if (cnt == WR_END) state <= DONE;
        end
        DONE: begin
          if (wrap) pending <= 1'b1;
          state <= IDLE;
        end
        REFRESH: begin
          // Wraps landing inside a refresh are dropped; exit clears the request.
          if (cnt == REF_END) begin
            state   <= IDLE;
            pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_bank_resp.sv
// Bench for jtframe_bank_resp: timestamp-based reference model plus directed literal checks.
module tb_jtframe_bank_resp;
  localparam int AW = 22, MW = 10, RD_L = 2, WR_L = 2, REF_P = 16, REF_L = 4, N = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd = 1'b0, wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [15:0]   din = '0;
  logic [1:0]    din_m = '0;
  logic          ack, dst, rdy, busy;
  logic [15:0]   data_read;

  jtframe_bank_resp #(.AW(AW), .MW(MW), .RD_LAT(RD_L), .WR_LAT(WR_L),
                      .REF_PERIOD(REF_P), .REF_LEN(REF_L)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .din(din), .din_m(din_m),
    .ack(ack), .dst(dst), .rdy(rdy), .data_read(data_read), .busy(busy));

  always #5 clk = ~clk;

  bit          exp_ack[N], exp_dst[N], exp_rdy[N], exp_busy[N], exp_clr[N];
  logic [15:0] exp_dd[N];
  logic [15:0] mem_m[1 << MW];
  int          cyc = 0, idle_from = 0, c0 = 0, ref_end = -1, wc = 0, wa = 0;
  bit          pend = 0, acc = 0, wv = 0, chk_en = 0;
  logic [15:0] wd = '0, shadow = '0;
  logic [1:0]  wm = '0;
  int          vectors = 0, miscompares = 0;

  typedef struct {int c; int f; logic [15:0] v; string n;} lit_t;
  lit_t lits[$];

  function automatic logic [15:0] fld(input int f);
    case (f)
      0: return {15'd0, ack};
      1: return {15'd0, dst};
      2: return {15'd0, rdy};
      3: return {15'd0, busy};
      default: return data_read;
    endcase
  endfunction

  task automatic cmp(input string n, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < N) begin
      if (exp_clr[cyc]) shadow = '0;
      if (exp_dst[cyc]) shadow = exp_dd[cyc];
      cmp("ack", 16'(ack), 16'(exp_ack[cyc]));
      cmp("dst", 16'(dst), 16'(exp_dst[cyc]));
      cmp("rdy", 16'(rdy), 16'(exp_rdy[cyc]));
      cmp("busy", 16'(busy), 16'(exp_busy[cyc]));
      cmp("data_read", data_read, shadow);
      for (int i = lits.size() - 1; i >= 0; i--)
        if (lits[i].c == cyc) begin
          cmp(lits[i].n, fld(lits[i].f), lits[i].v);
          lits.delete(i);
        end
    end
  end

  // Reference: the bank is free from idle_from on; each request books its pulses at fixed offsets.
  task automatic model_step(input int c);
    bit wrap;
    int a;
    acc = 0;
    exp_busy[c] = (c < idle_from);
    if (wv && wc == c) begin
      if (!rst) begin
        if (!wm[0]) mem_m[wa][7:0]  = wd[7:0];
        if (!wm[1]) mem_m[wa][15:8] = wd[15:8];
      end
      wv = 0;
    end
    if (rst) begin
      for (int i = c + 1; i < N; i++) begin
        exp_ack[i] = 0; exp_dst[i] = 0; exp_rdy[i] = 0; exp_busy[i] = 0; exp_clr[i] = 0;
      end
      exp_clr[c + 1] = 1;
      idle_from = c + 1; pend = 0; c0 = c + 1; ref_end = -1; wv = 0;
      return;
    end
    wrap = ((c - c0) % REF_P) == REF_P - 1;
    a = int'(addr[MW-1:0]);
    if (c >= idle_from) begin
      if (pend || wrap) begin
        ref_end = c + REF_L; idle_from = c + REF_L + 1; pend = 0;
      end else if (wr) begin
        acc = 1; exp_ack[c + 1] = 1; exp_rdy[c + WR_L] = 1;
        wv = 1; wc = c + 1; wa = a; wd = din; wm = din_m;
        idle_from = c + WR_L + 2;
      end else if (rd) begin
        acc = 1; exp_ack[c + 1] = 1;
        exp_dst[c + RD_L] = 1; exp_dd[c + RD_L] = mem_m[a];
        exp_rdy[c + RD_L + 1] = 1;
        idle_from = c + RD_L + 3;
      end
    end else if (wrap && c > ref_end) pend = 1;
  endtask

  task automatic step(input bit r, input bit rv, input bit wv_, input logic [AW-1:0] a,
                      input logic [15:0] d, input logic [1:0] m);
    rst = r; rd = rv; wr = wv_; addr = a; din = d; din_m = m;
    model_step(cyc);
    @(posedge clk); #1;
    cyc++;
    if (cyc >= N - 32) begin
      $display("FAIL cycle_budget: got %0d cycles expected below %0d", cyc, N - 32);
      $fatal(1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, '0, '0, '0);
  endtask

  task automatic lit(input int c, input int f, input logic [15:0] v, input string n);
    lit_t e;
    e.c = c; e.f = f; e.v = v; e.n = n;
    lits.push_back(e);
  endtask

  task automatic req(input bit rv, input bit wv_, input logic [AW-1:0] a, input logic [15:0] d,
                     input logic [1:0] m, output int t);
    int k = 0;
    acc = 0;
    t = cyc;
    while (!acc) begin
      t = cyc;
      step(0, rv, wv_, a, d, m);
      k++;
      if (k > 64) begin
        $display("FAIL accept_timeout: got no ack after %0d cycles expected one", k);
        $fatal(1);
      end
    end
    lit(t + 1, 0, 16'd1, "ack_at_t1");
  endtask

  task automatic wr_do(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
    int t;
    req(0, 1, a, d, m, t);
    lit(t + WR_L, 2, 16'd1, "wr_rdy");
    lit(t + WR_L, 1, 16'd0, "wr_no_dst");
  endtask

  task automatic rd_chk(input logic [AW-1:0] a, input logic [15:0] v, input string n);
    int t;
    req(1, 0, a, '0, '0, t);
    lit(t + RD_L, 1, 16'd1, "rd_dst");
    lit(t + RD_L, 4, v, n);
    lit(t + RD_L, 2, 16'd0, "rd_no_rdy_with_dst");
    lit(t + RD_L + 1, 2, 16'd1, "rd_rdy");
  endtask

  initial begin
    int t, w, k;
    bit hold, hrd, hwr, extra, r;
    logic [AW-1:0] ha;
    logic [15:0] hd;
    logic [1:0] hm;
    step(1, 0, 0, '0, '0, '0);
    chk_en = 1;
    lit(cyc, 3, 16'd0, "reset_busy");
    lit(cyc, 4, 16'd0, "reset_data");
    step(1, 0, 0, '0, '0, '0);

    wr_do(22'd5, 16'h1234, 2'b00);
    rd_chk(22'd5, 16'h1234, "rd_a5");
    wr_do(22'd7, 16'hFFFF, 2'b00);
    wr_do(22'd7, 16'hAB00, 2'b01);
    rd_chk(22'd7, 16'hABFF, "mask_lo");
    wr_do(22'd7, 16'h0000, 2'b11);
    rd_chk(22'd7, 16'hABFF, "mask_all");

    req(1, 1, 22'd3, 16'h5555, 2'b00, t);
    lit(t + 2, 2, 16'd1, "both_rdy");
    lit(t + 2, 1, 16'd0, "both_no_dst");
    lit(t + 3, 1, 16'd0, "both_no_dst2");
    rd_chk(22'd3, 16'h5555, "both_rd");

    wr_do(22'h000, 16'h00AA, 2'b00);
    rd_chk(22'h400, 16'h00AA, "alias_400");
    rd_chk(22'h3FFC00, 16'h00AA, "alias_hi");

    k = 0;
    while (!(cyc >= idle_from && !pend) || ((cyc - c0) % REF_P) != REF_P - 1) begin
      idle(1);
      k++;
      if (k > 200) begin
        $display("FAIL wrap_wait: got %0d cycles expected under 200", k);
        $fatal(1);
      end
    end
    w = cyc;
    for (int i = 1; i <= REF_L; i++) begin
      lit(w + i, 3, 16'd1, "ref_busy");
      lit(w + i, 0, 16'd0, "ref_no_ack");
    end
    lit(w + REF_L + 1, 3, 16'd0, "ref_exit_idle");
    lit(w + REF_L + 1, 0, 16'd0, "ref_exit_no_ack");
    lit(w + REF_L + 2, 0, 16'd1, "ref_ack");
    lit(w + REF_L + 7, 0, 16'd1, "held_second_ack");
    repeat (12) step(0, 1, 0, 22'd5, '0, '0);
    idle(8);

    wr_do(22'd9, 16'h9999, 2'b00);
    req(1, 0, 22'd9, '0, '0, t);
    for (int f = 0; f < 5; f++) lit(t + 2, f, 16'd0, "rst_outputs");
    lit(t + 3, 1, 16'd0, "rst_no_dst");
    lit(t + 3, 2, 16'd0, "rst_no_rdy");
    step(1, 0, 0, '0, '0, '0);
    idle(6);
    rd_chk(22'd9, 16'h9999, "rst_mem_kept");

    for (int i = 0; i < 16; i++) wr_do(AW'(i), 16'($urandom), 2'b00);
    hold = 0; hrd = 0; hwr = 0; extra = 0; ha = '0; hd = '0; hm = '0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if (!hold && $urandom_range(0, 2) != 0) begin
        k = int'($urandom_range(0, 3));
        hrd = (k != 1); hwr = (k <= 1);
        ha = {12'($urandom), 6'd0, 4'($urandom)};
        hd = 16'($urandom); hm = 2'($urandom);
        extra = ($urandom_range(0, 5) == 0);
        hold = 1;
      end
      step(r, hold & hrd, hold & hwr, ha, hd, hm);
      if (acc) begin
        hold = extra; extra = 0;
      end else if (hold && cyc < idle_from && !extra && exp_ack[cyc]) begin
        hold = 0;
      end
    end
    idle(12);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
